// File: rtl/tl_arb_pkg.sv
// Shared types and constants for the TileLink request arbiter and its helpers.
// Holds the FSM state encoding, payload widths and op codes.
package tl_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam int TL_ADDR_W = 64;
    localparam int TL_LEN_W  = 8;
    localparam int TL_OP_W   = 2;
    localparam int TL_DATA_W = 512;
    localparam int TL_STRB_W = 64;

    localparam logic [TL_OP_W-1:0] OP_READ  = 2'b00;
    localparam logic [TL_OP_W-1:0] OP_WRITE = 2'b01;

endpackage

// File: rtl/tl_req_arbiter_rr_pick.sv
// Combinational round-robin picker: the first asserted req searching upward from last+1.
// Kept standalone so other schedulers can reuse it.
module rr_pick #(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               any,
    output logic [IDX_W-1:0]   idx,
    output logic [NUM_REQ-1:0] onehot
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        any    = 1'b0;
        idx    = '0;
        onehot = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last) + k) % NUM_REQ);
            if (!any && req[cand]) begin
                any          = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tl_req_arbiter.sv
// Round-robin arbiter sharing one single-outstanding TL request/response port among
// NUM_REQ requesters, with a sticky response watchdog.
module tl_req_arbiter
    import tl_arb_pkg::*;
#(
    parameter int  NUM_REQ     = 4,
    parameter int  TIMEOUT_CYC = 4096,
    localparam int IDX_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            s_req_valid,
    output logic [NUM_REQ-1:0]            s_req_ready,
    input  logic [NUM_REQ*TL_ADDR_W-1:0]  s_req_addr,
    input  logic [NUM_REQ*TL_LEN_W-1:0]   s_req_len,
    input  logic [NUM_REQ*TL_OP_W-1:0]    s_req_op,
    input  logic [NUM_REQ*TL_DATA_W-1:0]  s_req_wdata,
    input  logic [NUM_REQ*TL_STRB_W-1:0]  s_req_wstrb,
    output logic [NUM_REQ-1:0]            s_resp_valid,
    input  logic [NUM_REQ-1:0]            s_resp_ready,
    output logic [TL_DATA_W-1:0]          s_resp_rdata,
    output logic [1:0]                    s_resp_code,
    output logic                          m_req_valid,
    input  logic                          m_req_ready,
    output logic [TL_ADDR_W-1:0]          m_req_addr,
    output logic [TL_LEN_W-1:0]           m_req_len,
    output logic [TL_OP_W-1:0]            m_req_op,
    output logic [TL_DATA_W-1:0]          m_req_wdata,
    output logic [TL_STRB_W-1:0]          m_req_wstrb,
    input  logic                          m_resp_valid,
    output logic                          m_resp_ready,
    input  logic [TL_DATA_W-1:0]          m_resp_rdata,
    input  logic [1:0]                    m_resp_code,
    output logic                          busy,
    output logic [IDX_W-1:0]              owner,
    output logic                          timeout_err
);

    localparam int              WD_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);

    state_t               state_reg, state_next;
    logic [IDX_W-1:0]     owner_reg, rr_last_reg;
    logic [WD_W-1:0]      wd_cnt_reg;
    logic                 timeout_err_reg;
    logic [TL_ADDR_W-1:0] addr_reg;
    logic [TL_LEN_W-1:0]  len_reg;
    logic [TL_OP_W-1:0]   op_reg;
    logic [TL_DATA_W-1:0] wdata_reg;
    logic [TL_STRB_W-1:0] wstrb_reg;

    logic                 pick_any;
    logic [IDX_W-1:0]     pick_idx;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic                 grant;
    logic                 resp_hs;

    logic [TL_ADDR_W-1:0] req_addr  [NUM_REQ];
    logic [TL_LEN_W-1:0]  req_len   [NUM_REQ];
    logic [TL_OP_W-1:0]   req_op    [NUM_REQ];
    logic [TL_DATA_W-1:0] req_wdata [NUM_REQ];
    logic [TL_STRB_W-1:0] req_wstrb [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_addr[gi]  = s_req_addr[gi*TL_ADDR_W +: TL_ADDR_W];
        assign req_len[gi]   = s_req_len[gi*TL_LEN_W +: TL_LEN_W];
        assign req_op[gi]    = s_req_op[gi*TL_OP_W +: TL_OP_W];
        assign req_wdata[gi] = s_req_wdata[gi*TL_DATA_W +: TL_DATA_W];
        assign req_wstrb[gi] = s_req_wstrb[gi*TL_STRB_W +: TL_STRB_W];
    end

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req    (s_req_valid),
        .last   (rr_last_reg),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    always_comb begin
        state_next   = state_reg;
        s_req_ready  = '0;
        s_resp_valid = '0;
        s_resp_rdata = '0;
        s_resp_code  = '0;
        m_resp_ready = 1'b0;
        grant        = 1'b0;
        resp_hs      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (pick_any) begin
                    s_req_ready = pick_onehot;
                    grant       = 1'b1;
                    state_next  = S_REQ;
                end
            end
            S_REQ: begin
                // A response arriving here is a bridge protocol error; leave it unacknowledged.
                if (m_req_ready) state_next = S_WAIT;
            end
            S_WAIT: begin
                s_resp_valid[owner_reg] = m_resp_valid;
                m_resp_ready            = s_resp_ready[owner_reg];
                s_resp_rdata            = m_resp_rdata;
                s_resp_code             = m_resp_code;
                resp_hs                 = m_resp_valid && s_resp_ready[owner_reg];
                if (resp_hs) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            owner_reg       <= '0;
            rr_last_reg     <= IDX_W'(NUM_REQ - 1);
            wd_cnt_reg      <= '0;
            timeout_err_reg <= 1'b0;
            addr_reg        <= '0;
            len_reg         <= '0;
            op_reg          <= '0;
            wdata_reg       <= '0;
            wstrb_reg       <= '0;
        end else begin
            state_reg <= state_next;
            if (grant) begin
                owner_reg   <= pick_idx;
                rr_last_reg <= pick_idx;
                addr_reg    <= req_addr[pick_idx];
                len_reg     <= req_len[pick_idx];
                op_reg      <= req_op[pick_idx];
                wdata_reg   <= req_wdata[pick_idx];
                wstrb_reg   <= req_wstrb[pick_idx];
            end
            if (state_reg == S_REQ && m_req_ready) begin
                wd_cnt_reg <= '0;
            end else if (state_reg == S_WAIT) begin
                // Watchdog only flags; the transaction keeps waiting for the bridge.
                if (!resp_hs && wd_cnt_reg != WD_MAX) wd_cnt_reg <= wd_cnt_reg + 1'b1;
                if (wd_cnt_reg == WD_MAX) timeout_err_reg <= 1'b1;
            end
        end
    end

    assign m_req_valid = (state_reg == S_REQ);
    assign m_req_addr  = addr_reg;
    assign m_req_len   = len_reg;
    assign m_req_op    = op_reg;
    assign m_req_wdata = wdata_reg;
    assign m_req_wstrb = wstrb_reg;
    assign busy        = (state_reg != S_IDLE);
    assign owner       = owner_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_tl_req_arbiter.sv
// Randomized scoreboard bench for tl_req_arbiter: a transaction-phase reference model
// predicts grants, bridge requests and responses; a negedge monitor checks the DUT.
module tb_tl_req_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;
    localparam int PH_IDLE = 0, PH_REQ = 1, PH_WAIT = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   s_req_valid;
    logic [N-1:0]   s_req_ready;
    logic [N*64-1:0]  s_req_addr;
    logic [N*8-1:0]   s_req_len;
    logic [N*2-1:0]   s_req_op;
    logic [N*512-1:0] s_req_wdata;
    logic [N*64-1:0]  s_req_wstrb;
    logic [N-1:0]   s_resp_valid;
    logic [N-1:0]   s_resp_ready;
    logic [511:0]   s_resp_rdata;
    logic [1:0]     s_resp_code;
    logic           m_req_valid;
    logic           m_req_ready;
    logic [63:0]    m_req_addr;
    logic [7:0]     m_req_len;
    logic [1:0]     m_req_op;
    logic [511:0]   m_req_wdata;
    logic [63:0]    m_req_wstrb;
    logic           m_resp_valid;
    logic           m_resp_ready;
    logic [511:0]   m_resp_rdata;
    logic [1:0]     m_resp_code;
    logic           busy;
    logic [1:0]     owner;
    logic           timeout_err;

    tl_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_req_addr(s_req_addr), .s_req_len(s_req_len), .s_req_op(s_req_op),
        .s_req_wdata(s_req_wdata), .s_req_wstrb(s_req_wstrb),
        .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready),
        .s_resp_rdata(s_resp_rdata), .s_resp_code(s_resp_code),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_req_addr(m_req_addr), .m_req_len(m_req_len), .m_req_op(m_req_op),
        .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
        .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready),
        .m_resp_rdata(m_resp_rdata), .m_resp_code(m_resp_code),
        .busy(busy), .owner(owner), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [N-1:0] onehot; } grant_t;
    typedef struct { logic [63:0] addr; logic [7:0] len; logic [1:0] op;
                     logic [511:0] wdata; logic [63:0] wstrb; } breq_t;
    typedef struct { logic [N-1:0] onehot; logic [511:0] rdata; logic [1:0] code; } resp_t;

    grant_t grant_q[$];
    breq_t  br_q[$];
    resp_t  resp_q[$];

    int chk_cnt = 0, pass_cnt = 0;
    int cyc = 0;
    bit running = 0;

    // reference model state
    int ph, rr_last, exp_owner, win, waited, lat, done;
    int force_lat = -1, req_pct = 30;
    bit granted, exp_to;
    logic [N-1:0] force_mask;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int w = 0; w < 16; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic load_req(input int i);
        s_req_valid[i]          = 1'b1;
        s_req_addr[i*64 +: 64]  = {$urandom, $urandom};
        s_req_len[i*8 +: 8]     = 8'($urandom);
        s_req_op[i*2 +: 2]      = 2'($urandom_range(0, 1));
        s_req_wdata[i*512 +: 512] = rand512();
        s_req_wstrb[i*64 +: 64] = {$urandom, $urandom};
    endtask

    task automatic model_reset();
        ph = PH_IDLE; rr_last = N - 1; exp_owner = 0; exp_to = 0;
        granted = 0; waited = 0; lat = 0;
        grant_q.delete(); br_q.delete(); resp_q.delete();
    endtask

    // One clock: advance the phase model from what happened at the edge, then drive new inputs.
    task automatic step();
        @(posedge clk); #1;
        case (ph)
            PH_IDLE: if (granted) begin
                ph = PH_REQ; rr_last = win; exp_owner = win;
                s_req_valid[win] = 1'b0; granted = 0;
            end
            PH_REQ: if (m_req_ready) begin
                ph = PH_WAIT; waited = 0; m_resp_valid = 1'b0;
                lat = (force_lat >= 0) ? force_lat : $urandom_range(0, 6);
            end
            default: begin
                waited++;
                if (waited >= TO) exp_to = 1;
                if (m_resp_valid && s_resp_ready[exp_owner]) begin
                    ph = PH_IDLE; m_resp_valid = 1'b0; done++;
                end
            end
        endcase
        if (force_mask != '0) begin
            for (int i = 0; i < N; i++) if (force_mask[i]) load_req(i);
            force_mask = '0;
        end else begin
            for (int i = 0; i < N; i++)
                if (!s_req_valid[i] && $urandom_range(0, 99) < req_pct) load_req(i);
        end
        m_req_ready  = ($urandom_range(0, 99) < 60);
        s_resp_ready = N'($urandom);
        case (ph)
            PH_IDLE: m_resp_valid = 1'b0;
            PH_REQ: begin
                m_resp_valid = ($urandom_range(0, 9) == 0);
                m_resp_rdata = rand512();
                m_resp_code  = 2'($urandom);
            end
            default: if (!m_resp_valid) begin
                if (lat == 0) begin
                    m_resp_valid = 1'b1;
                    m_resp_rdata = rand512();
                    m_resp_code  = 2'($urandom);
                    resp_q.push_back('{N'(1) << exp_owner, m_resp_rdata, m_resp_code});
                end else lat--;
            end
        endcase
        if (ph == PH_IDLE) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (rr_last + k) % N;
                if (!granted && s_req_valid[c]) begin granted = 1; win = c; end
            end
            if (granted) begin
                grant_q.push_back('{cyc, N'(1) << win});
                br_q.push_back('{s_req_addr[win*64 +: 64], s_req_len[win*8 +: 8],
                                 s_req_op[win*2 +: 2], s_req_wdata[win*512 +: 512],
                                 s_req_wstrb[win*64 +: 64]});
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; #1;
        chk("rst_busy", busy, 0);
        chk("rst_mreq_valid", m_req_valid, 0);
        chk("rst_sresp_valid", s_resp_valid, 0);
        chk("rst_mresp_ready", m_resp_ready, 0);
        chk("rst_rdata", s_resp_rdata, 0);
        chk("rst_owner", owner, 0);
        chk("rst_timeout", timeout_err, 0);
        s_req_valid = '0; m_resp_valid = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Monitor: pops expectations when the DUT presents a handshake, plus per-cycle phase checks.
    grant_t g;
    breq_t  b;
    resp_t  r;
    always @(negedge clk) begin
        if (running && rst_n) begin
            chk("busy", busy, ph != PH_IDLE);
            chk("m_req_valid", m_req_valid, ph == PH_REQ);
            chk("timeout_err", timeout_err, exp_to);
            chk("owner", owner, exp_owner);
            if (s_req_ready != '0) begin
                if (grant_q.size() == 0) chk("unexpected_grant", s_req_ready, 0);
                else begin
                    g = grant_q.pop_front();
                    chk("grant_cycle", cyc, g.cyc);
                    chk("grant_onehot", s_req_ready, g.onehot);
                end
            end
            if (m_req_valid) begin
                if (br_q.size() == 0) chk("unexpected_mreq", m_req_valid, 0);
                else begin
                    b = br_q[0];
                    chk("m_req_addr", m_req_addr, b.addr);
                    chk("m_req_len", m_req_len, b.len);
                    chk("m_req_op", m_req_op, b.op);
                    chk("m_req_wdata", m_req_wdata, b.wdata);
                    chk("m_req_wstrb", m_req_wstrb, b.wstrb);
                    if (m_req_ready) void'(br_q.pop_front());
                end
            end
            if (ph == PH_WAIT) begin
                chk("m_resp_ready", m_resp_ready, s_resp_ready[exp_owner]);
                chk("s_resp_valid", s_resp_valid, m_resp_valid ? (N'(1) << exp_owner) : '0);
                if ((s_resp_valid & s_resp_ready) != '0) begin
                    if (resp_q.size() == 0) chk("unexpected_resp", s_resp_valid, 0);
                    else begin
                        r = resp_q.pop_front();
                        chk("resp_onehot", s_resp_valid, r.onehot);
                        chk("resp_rdata", s_resp_rdata, r.rdata);
                        chk("resp_code", s_resp_code, r.code);
                    end
                end
            end else begin
                chk("idle_resp_valid", s_resp_valid, 0);
                chk("idle_mresp_ready", m_resp_ready, 0);
                chk("idle_rdata", s_resp_rdata, 0);
                chk("idle_code", s_resp_code, 0);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        s_req_valid = '0; s_req_addr = '0; s_req_len = '0; s_req_op = '0;
        s_req_wdata = '0; s_req_wstrb = '0; s_resp_ready = '0;
        m_req_ready = 1'b0; m_resp_valid = 1'b0; m_resp_rdata = '0; m_resp_code = '0;
        force_mask = '0; done = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("init_busy", busy, 0);
        chk("init_owner", owner, 0);
        chk("init_timeout", timeout_err, 0);
        chk("init_mreq_valid", m_req_valid, 0);
        chk("init_sreq_ready", s_req_ready, 0);
        rst_n = 1'b1;
        running = 1;

        // requesters 0 and 2 first, then sparse random traffic
        force_mask = 4'b0101;
        repeat (600) step();
        // every requester continuously valid
        req_pct = 100;
        repeat (300) step();
        // slow bridge: response latency beyond the watchdog
        req_pct = 30; force_lat = 30;
        repeat (200) step();
        chk("timeout_sticky", timeout_err, 1);
        force_lat = -1;
        // reset in the middle of a response wait
        for (int n = 0; n < 100 && ph != PH_WAIT; n++) step();
        chk("reached_wait", busy, 1);
        do_reset();
        force_mask = 4'b1111;
        repeat (300) step();
        chk("progress", done > 50, 1);

        running = 0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/tl_req_arbiter.md
Name: tl_req_arbiter

Overview:
- Shares the single-outstanding TileLink-style request/response port of the TL→AVM bridge AFU among NUM_REQ requesters (e.g. host CSR path, DMA engine, scrubber).
- Grants requesters round-robin, registers the winning request, forwards it to the bridge, and holds the grant until the bridge response handshake completes.
- Routes the response back to the owning requester and runs a response watchdog.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDX_W, $clog2(NUM_REQ), owner index width (derived localparam)
TIMEOUT_CYC, 4096, cycles in S_WAIT before timeout flag sets (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_req_valid  in  NUM_REQ  per-requester request valid
s_req_ready  out  NUM_REQ  per-requester request accept (one-hot or zero)
s_req_addr  in  NUM_REQ*64  packed request addresses, requester i at [64i+:64]
s_req_len  in  NUM_REQ*8  packed lengths
s_req_op  in  NUM_REQ*2  packed ops (00 read, 01 write)
s_req_wdata  in  NUM_REQ*512  packed write data
s_req_wstrb  in  NUM_REQ*64  packed byte strobes
s_resp_valid  out  NUM_REQ  per-requester response valid (one-hot or zero)
s_resp_ready  in  NUM_REQ  per-requester response ready
s_resp_rdata  out  512  shared response data (qualified by s_resp_valid)
s_resp_code  out  2  shared response code
m_req_valid  out  1  request to bridge
m_req_ready  in  1  bridge accepts request
m_req_addr  out  64  registered address
m_req_len  out  8  registered length
m_req_op  out  2  registered op
m_req_wdata  out  512  registered write data
m_req_wstrb  out  64  registered strobes
m_resp_valid  in  1  bridge response valid
m_resp_ready  out  1  bridge response ready
m_resp_rdata  in  512  bridge response data
m_resp_code  in  2  bridge response code
busy  out  1  1 whenever state != S_IDLE
owner  out  IDX_W  index of current/last granted requester
timeout_err  out  1  sticky watchdog flag; cleared only by reset

Behaviour:
- Reset (asynchronous, immediate):
  - state=S_IDLE; rr_last=NUM_REQ-1, so requester 0 has highest priority first.
  - owner=0, timeout_err=0, wd_cnt=0, payload registers=0.
  - All valid/ready outputs are 0 except in S_IDLE, where s_req_ready follows arbitration.
- Reset mid-transaction drops the transaction silently; the bridge is reset on the same domain.
- States:
  - S_IDLE: winner = first i with s_req_valid[i], searching rr_last+1, rr_last+2, ... mod NUM_REQ. If any valid: s_req_ready[winner]=1 combinationally, capture payload and owner=winner, rr_last<=winner, go to S_REQ. Else stay.
  - S_REQ: m_req_valid=1 with registered payload. On m_req_ready go to S_WAIT and clear wd_cnt.
  - S_WAIT: m_resp_valid drives s_resp_valid[owner], and m_resp_ready=s_resp_ready[owner]. s_resp_rdata/code pass through combinationally.
    - On m_resp_valid && s_resp_ready[owner], go to S_IDLE.
    - wd_cnt increments while no handshake occurs. When wd_cnt reaches TIMEOUT_CYC-1, timeout_err<=1. Stay in S_WAIT; there is no abort.
- Latency: request grant to m_req_valid is 1 cycle. Response path is 0 cycles.
- The arbiter makes no new grant until the current response handshake completes, so at most one transaction is in flight.
- A single requester may win on consecutive transactions only if no other requester is valid.
- s_req_ready is never asserted outside S_IDLE, and never for a non-winner.
- Requesters must hold valid and payload until ready; the arbiter does not check this.
- m_req_valid stays high until m_req_ready, with payload stable.
- A response with m_resp_valid while in S_REQ is a protocol violation: ignore it, and keep m_resp_ready=0.
- wd_cnt saturates at TIMEOUT_CYC-1. Its width is $clog2(TIMEOUT_CYC+1).
- s_resp_rdata and s_resp_code are 0 outside S_WAIT.

Decomposition:
- Shared package tl_arb_pkg: state_t enum (S_IDLE, S_REQ, S_WAIT), width constants TL_ADDR_W=64, TL_LEN_W=8, TL_OP_W=2, TL_DATA_W=512, TL_STRB_W=64, and op codes OP_READ=2'b00, OP_WRITE=2'b01.
- One sub-module, rr_pick: combinational round-robin picker with inputs req[NUM_REQ] and last[IDX_W], and outputs any, idx and onehot. It is reusable by the DMA scheduler.

Test Plan:
- After reset, requesters 0 and 2 both valid -> s_req_ready=4'b0001; next cycle m_req_valid=1 with requester 0's addr; then grant 2 after requester 0's response completes.
- All 4 requesters continuously valid, bridge ready=1 and response after 3 cycles -> grant order 0,1,2,3,0,...; per-grant cadence of 6 cycles; owner tracks grant.
- Requester 1 write (addr 0x1000, wstrb all-ones) with bridge holding m_req_ready=0 for 5 cycles -> m_req_valid and payload stable for 5 cycles; no s_req_ready pulses meanwhile.
- Bridge returns code 2'b10 while s_resp_ready[owner]=0 for 3 cycles -> s_resp_valid[owner]=1 and m_resp_ready=0 held; handshake on cycle 4; return to S_IDLE.
- TIMEOUT_CYC=16, no bridge response -> timeout_err=1 after 16 cycles in S_WAIT, stays 1; a later response still completes normally.
- Assert rst_n low during S_WAIT -> all outputs are reset values immediately; busy=0; next grant goes to requester 0.
